cache_slave_mem: RTL and testbench

Wait-state backing-memory responder for the slave port of the direct-mapped cache (`o_slave_sel` / `o_slave_addr` / `i_slave_rdata` / `i_slave_ready`). It answers word-read requests from the cache line-fill engine. Each answer comes from an internal preloadable word array after a programmable number of wait states, with a shorter penalty for back-to-back sequential addresses. It serves as both the system flash/ROM model and the bench responder for the cache.

---
 rtl/cache_pkg.sv | 9 +
 rtl/cache_slave_array.sv | 22 ++
 rtl/cache_slave_mem.sv | 92 +++++++++
 tb/tb_cache_slave_mem.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states, bus widths and address range helper for the cache slave port
package cache_pkg;
  localparam int ADDR_WIDTH = 30;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a, input int aw);
    return (a >> aw) != '0;
  endfunction
endpackage

// File: rtl/cache_slave_array.sv
// cache_slave_array: 2**AW x 32 word array, sync read, one write port, read-before-write
// Ports: i_clk clock; i_we/i_waddr/i_wdata write port; i_raddr read address; o_rdata data one cycle later
module cache_slave_array
  import cache_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] mem [2**AW];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    rdata_q <= mem[i_raddr];
  end
  assign o_rdata = rdata_q;
endmodule

// File: rtl/cache_slave_mem.sv
// cache_slave_mem: wait-state word-read responder with sequential fast path and preload port
// Ports: i_clk/i_reset; i_sel/i_addr request; o_rdata/o_ready/o_err response; i_load_* preload write
module cache_slave_mem
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int WAIT_FIRST = 3,
  parameter int WAIT_SEQ   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sel,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ready,
  output logic                  o_err,
  input  logic                  i_load_we,
  input  logic [ADDR_W-1:0]     i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data
);
  localparam int CW = (WAIT_FIRST > 0) ? $clog2(WAIT_FIRST + 1) : 1;
  state_t                state_q;
  logic [CW-1:0]         cnt_q, ld;
  logic                  win_q, ready_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q, last_q;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic [ADDR_W-1:0]     raddr;
  // The array is read every cycle; only the read on the edge into RESP is ever presented.
  // From IDLE a zero-wait request has not latched its address yet, so read straight from the bus.
  assign raddr = state_q == IDLE ? i_addr[ADDR_W-1:0] : addr_q[ADDR_W-1:0];
  // The sequential window is win_q, which is only ever high in the IDLE cycle right after RESP.
  assign ld = (win_q && i_addr == last_q + 30'd1) ? CW'(WAIT_SEQ) : CW'(WAIT_FIRST);
  cache_slave_array #(.AW(ADDR_W)) u_array (
    .i_clk   (i_clk),
    .i_we    (i_load_we),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_raddr (raddr),
    .o_rdata (arr_rdata)
  );
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      last_q  <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          win_q <= 1'b0;
          if (i_sel) begin
            addr_q  <= i_addr;
            cnt_q   <= ld;
            state_q <= ld == '0 ? RESP : WAIT;
            ready_q <= ld == '0;
            err_q   <= ld == '0 && out_of_range(i_addr, ADDR_W);
          end
        end
        WAIT: begin
          if (!i_sel) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (i_addr != addr_q) begin
            addr_q <= i_addr;
            cnt_q  <= CW'(WAIT_FIRST);
          end else if (cnt_q <= CW'(1)) begin
            state_q <= RESP;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            err_q   <= out_of_range(addr_q, ADDR_W);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          win_q   <= 1'b1;
          last_q  <= addr_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_ready = ready_q;
  assign o_err   = err_q;
  assign o_rdata = (ready_q && !err_q) ? arr_rdata : '0;
endmodule

// File: tb/tb_cache_slave_mem.sv
// tb_cache_slave_mem: directed checks of latency, sequential path, abort, restart, range, reset, collision
module tb_cache_slave_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] rdata;
  logic        ready, err;
  logic        load_we = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  cache_slave_mem dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_sel       (sel),
    .i_addr      (addr),
    .o_rdata     (rdata),
    .o_ready     (ready),
    .o_err       (err),
    .i_load_we   (load_we),
    .i_load_addr (load_addr),
    .i_load_data (load_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %h expected %h", tag, got, exp);
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    load_we = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_we = 1'b0;
  endtask

  // Request presented in the current cycle; ready expected exactly lat cycles later.
  // With collide set, a preload of cd to the same word lands on the edge of the array read.
  task automatic req(input string tag, input logic [29:0] a, input int lat,
                     input logic [31:0] d, input logic e, input bit collide, input logic [31:0] cd);
    sel = 1'b1;
    addr = a;
    for (int i = 1; i < lat; i++) begin
      step();
      chk({tag, "_busy"}, {31'd0, ready}, 32'd0);
      if (collide && i == lat - 1) begin
        load_we = 1'b1;
        load_addr = a[9:0];
        load_data = cd;
      end
    end
    step();
    load_we = 1'b0;
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_data"}, rdata, d);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
    sel = 1'b0;
    step();
  endtask

  initial begin
    step();
    step();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_data", rdata, 32'd0);
    rst = 1'b0;
    load(10'd0, 32'hC0DE_0000);
    load(10'd3, 32'hC0DE_0003);
    load(10'd5, 32'hA5A5_0005);
    load(10'd6, 32'hC0DE_0006);
    load(10'd7, 32'hC0DE_0007);
    for (int k = 8; k < 12; k++) load(10'(k), 32'hC0DE_0000 | k);
    load(10'd20, 32'hC0DE_0014);
    load(10'd21, 32'hC0DE_0015);
    load(10'h3FF, 32'hC0DE_03FF);
    step();

    req("single", 30'd5, 4, 32'hA5A5_0005, 1'b0, 1'b0, 32'd0);
    step();

    req("seq8", 30'd8, 4, 32'hC0DE_0008, 1'b0, 1'b0, 32'd0);
    req("seq9", 30'd9, 2, 32'hC0DE_0009, 1'b0, 1'b0, 32'd0);
    req("seq10", 30'd10, 2, 32'hC0DE_000A, 1'b0, 1'b0, 32'd0);
    req("seq11", 30'd11, 2, 32'hC0DE_000B, 1'b0, 1'b0, 32'd0);
    req("same11", 30'd11, 4, 32'hC0DE_000B, 1'b0, 1'b0, 32'd0);
    step();

    req("pre20", 30'd20, 4, 32'hC0DE_0014, 1'b0, 1'b0, 32'd0);
    sel = 1'b1;
    addr = 30'd30;
    step();
    step();
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_noready", {31'd0, ready}, 32'd0);
    end
    req("after_abort21", 30'd21, 4, 32'hC0DE_0015, 1'b0, 1'b0, 32'd0);
    step();

    sel = 1'b1;
    addr = 30'd3;
    step();
    addr = 30'd7;
    req("addr_change", 30'd7, 4, 32'hC0DE_0007, 1'b0, 1'b0, 32'd0);
    step();

    req("oor400", 30'h400, 4, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("oor_err_pulse", {31'd0, err}, 32'd0);
    req("top3ff", 30'h3FF, 4, 32'hC0DE_03FF, 1'b0, 1'b0, 32'd0);
    step();
    req("wrap_hi", 30'h3FFF_FFFF, 4, 32'd0, 1'b1, 1'b0, 32'd0);
    req("wrap_0", 30'd0, 2, 32'hC0DE_0000, 1'b0, 1'b0, 32'd0);
    step();

    sel = 1'b1;
    addr = 30'd6;
    step();
    step();
    rst = 1'b1;
    sel = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_data", rdata, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("midrst_noready", {31'd0, ready}, 32'd0);
    end
    req("post_rst6", 30'd6, 4, 32'hC0DE_0006, 1'b0, 1'b0, 32'd0);
    step();

    req("collide_old", 30'd5, 4, 32'hA5A5_0005, 1'b0, 1'b1, 32'h1234_5678);
    step();
    req("collide_new", 30'd5, 4, 32'h1234_5678, 1'b0, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
